control_sequencer: RTL and testbench

Hard-wired Moore control unit that sits directly upstream of the processor datapath and drives all of its bus-out, register-in, memory and ALU-opcode strobes. It fetches each instruction through PC -> MAR -> MDR -> IR, decodes the IR opcode and register fields, then sequences the execute steps for register-register ALU, multiply/divide, and unary instructions. Outputs are a pure decode of the registered state, so every strobe is stable for a whole clock cycle.

---
 rtl/control_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
// Hard-wired Moore control unit for the processor datapath. It fetches each
// instruction (PC -> MAR -> MDR -> IR), decodes the IR opcode and register
// fields, and sequences the execute steps for register-register ALU,
// multiply/divide and unary instructions. Strobes decode the registered
// state (and the IR, which is stable from T3), so each strobe lasts a whole
// clock cycle.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   When defined, adds input 'step'. END moves to PAUSE, which holds
//   (busy=0) until a rising edge on step (-> T0), or returns to IDLE when
//   run=0.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   run          1 = fetch/execute, 0 = stop at next instruction boundary
//   ir[31:0]     IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   mem_ready    memory read data valid (only observed in T1)
//   step         (SEQ_SINGLE_STEP_EN only) single-step request
//   *_out        bus source strobes
//   *_in         register load strobes
//   inc_pc/read  PC increment / memory read
//   reg_out_sel  one-hot general-register bus source
//   reg_in_sel   one-hot general-register load
//   alu_op       ALU opcode
//   busy         high outside IDLE/HALT (and PAUSE)
//   halted       high in HALT
//   illegal      one-cycle pulse on an unsupported opcode
//   read_timeout sticky; set when the T1 wait reaches MEM_WAIT_MAX

module control_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        pc_out,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        mdr_out,
  output logic        lo_out,
  output logic        hi_out,
  output logic        mar_in,
  output logic        z_in,
  output logic        pc_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        read,
  output logic [15:0] reg_out_sel,
  output logic [15:0] reg_in_sel,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        read_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_END, S_HALT, S_PAUSE
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       tmo_q, tmo_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md, is_un, is_nop, is_halt, is_exec;
  logic       unused_ir_bits;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  // add, sub, shr, shl, ror, rol, and, or occupy the contiguous range 3..10
  assign is_alu  = (opcode >= 5'b00011) && (opcode <= 5'b01010);
  assign is_md   = (opcode == 5'b01110) || (opcode == 5'b01111);
  assign is_un   = (opcode == 5'b10000) || (opcode == 5'b10001);
  assign is_nop  = (opcode == 5'b11010);
  assign is_halt = (opcode == 5'b11011);
  assign is_exec = is_alu || is_md || is_un;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) step_q <= 1'b0;
    else      step_q <= step;
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wcnt_d  = 4'd0;
      end
      S_T1: begin
        if (mem_ready) state_d = S_T2;
        else if (wcnt_q != WAIT_MAX) wcnt_d = wcnt_q + 4'd1;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_halt)      state_d = S_HALT;
        else if (is_exec) state_d = S_T4;
        else              state_d = S_END;   // nop and illegal
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = is_md ? S_T6 : S_END;
      S_T6: state_d = S_END;
`ifdef SEQ_SINGLE_STEP_EN
      S_END: state_d = run ? S_PAUSE : S_IDLE;
      S_PAUSE: begin
        if (!run)                 state_d = S_IDLE;
        else if (step && !step_q) state_d = S_T0;
      end
`else
      S_END: state_d = run ? S_T0 : S_IDLE;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Counter saturates at the limit, so this stays true until the next T0;
    // the flag itself is only cleared by reset.
    if (wcnt_d == WAIT_MAX) tmo_d = 1'b1;
  end

  always_comb begin
    pc_out      = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    mdr_out     = 1'b0;
    lo_out      = 1'b0;
    hi_out      = 1'b0;
    mar_in      = 1'b0;
    z_in        = 1'b0;
    pc_in       = 1'b0;
    mdr_in      = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    inc_pc      = 1'b0;
    read        = 1'b0;
    reg_out_sel = 16'h0000;
    reg_in_sel  = 16'h0000;
    alu_op      = 5'b00000;
    illegal     = 1'b0;
    busy        = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_PAUSE));
    halted      = (state_q == S_HALT);
    case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_exec) begin
          reg_out_sel = 16'h0001 << rb;
          y_in        = 1'b1;
        end else if (!is_nop && !is_halt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        alu_op      = opcode;
        z_in        = 1'b1;
        reg_out_sel = is_un ? (16'h0001 << rb) : (16'h0001 << rc);
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_md) lo_in = 1'b1;
        else       reg_in_sel = 16'h0001 << ra;   // Ra written last
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign read_timeout = tmo_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [31:0] ir;
  logic        pc_out, zlow_out, zhigh_out, mdr_out, lo_out, hi_out;
  logic        mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in;
  logic        inc_pc, read;
  logic [15:0] reg_out_sel, reg_in_sel;
  logic [4:0]  alu_op;
  logic        busy, halted, illegal, read_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // strobe vector bit positions (see strb())
  localparam logic [15:0] PC_OUT = 16'h8000, ZLOW  = 16'h4000, ZHIGH  = 16'h2000,
                          MDR_OUT= 16'h1000, LO_OUT= 16'h0800, HI_OUT = 16'h0400,
                          MAR_IN = 16'h0200, Z_IN  = 16'h0100, PC_IN  = 16'h0080,
                          MDR_IN = 16'h0040, IR_IN = 16'h0020, Y_IN   = 16'h0010,
                          HI_IN  = 16'h0008, LO_IN = 16'h0004, INC_PC = 16'h0002,
                          READ   = 16'h0001;
  localparam logic [15:0] T0S = PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam logic [15:0] T1S = ZLOW | PC_IN | READ | MDR_IN;
  localparam logic [15:0] T2S = MDR_OUT | IR_IN;

  control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .mdr_out(mdr_out), .lo_out(lo_out), .hi_out(hi_out),
    .mar_in(mar_in), .z_in(z_in), .pc_in(pc_in), .mdr_in(mdr_in),
    .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .read(read),
    .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal), .read_timeout(read_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] strb();
    return {pc_out, zlow_out, zhigh_out, mdr_out, lo_out, hi_out, mar_in, z_in,
            pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, inc_pc, read};
  endfunction

  task automatic chk_st(input string tag, input logic [15:0] s,
                        input logic [15:0] osel, input logic [15:0] isel);
    chk({tag, " strb"}, strb(), s);
    chk({tag, " out_sel"}, reg_out_sel, osel);
    chk({tag, " in_sel"}, reg_in_sel, isel);
  endtask

  // From IDLE (or END with run=1): T0, T1 (mem_ready high), T2.
  task automatic fetch(input string tag, input logic [31:0] instr);
    ir = instr; run = 1'b1; mem_ready = 1'b1;
    tick(); chk_st({tag, " T0"}, T0S, 16'h0, 16'h0); chk({tag, " T0 busy"}, busy, 1'b1);
    tick(); chk_st({tag, " T1"}, T1S, 16'h0, 16'h0);
    tick(); chk_st({tag, " T2"}, T2S, 16'h0, 16'h0);
  endtask

  // From T2 with run already dropped: T3..T5 (T6), END, then IDLE.
  task automatic exec(input string tag, input logic [15:0] t3, input logic [15:0] t4,
                      input logic [4:0] op, input logic [15:0] t5s,
                      input logic [15:0] ra, input bit md);
    tick(); chk_st({tag, " T3"}, Y_IN, t3, 16'h0);
    tick(); chk_st({tag, " T4"}, Z_IN, t4, 16'h0); chk({tag, " T4 alu_op"}, alu_op, op);
    tick(); chk_st({tag, " T5"}, t5s, 16'h0, ra);
    if (md) begin
      tick(); chk_st({tag, " T6"}, ZHIGH | HI_IN, 16'h0, 16'h0);
    end
    tick(); chk_st({tag, " END"}, 16'h0, 16'h0, 16'h0); chk({tag, " END busy"}, busy, 1'b1);
    tick(); chk({tag, " IDLE busy"}, busy, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && busy; k++) tick();
    chk(tag, busy, 1'b0);
  endtask

  // Cycle count from T0 (cycle 1) to the final write strobe.
  task automatic lat(input string tag, input logic [31:0] instr, input int exp, input bit md);
    int n;
    ir = instr; run = 1'b1; mem_ready = 1'b1;
    tick(); chk({tag, " T0"}, strb(), T0S);
    run = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); n++;
      if (md ? hi_in : (reg_in_sel != 16'h0)) break;
    end
    chk(tag, n + 1, exp);
    wait_idle({tag, " idle"});
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    repeat (2) tick();
    chk_st("reset", 16'h0, 16'h0, 16'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset halted", halted, 1'b0);
    chk("reset timeout", read_timeout, 1'b0);
    chk("reset alu_op", alu_op, 5'd0);
    clr = 1'b1;
    tick(); chk("idle run0 busy", busy, 1'b0);

    // add R1,R2,R3 ; run dropped during T2
    fetch("add", 32'h18918000); run = 1'b0;
    exec("add", 16'h0004, 16'h0008, 5'b00011, ZLOW, 16'h0002, 1'b0);
    lat("add latency", 32'h18918000, 6, 1'b0);

    // mul R2,R3 -> LO/HI, no general register write
    fetch("mul", 32'h70918000); run = 1'b0;
    exec("mul", 16'h0004, 16'h0008, 5'b01110, ZLOW | LO_IN, 16'h0000, 1'b1);
    lat("mul latency", 32'h70918000, 7, 1'b1);

    // not R5,R9 with run dropped in T2
    fetch("not", 32'h8AC80000); run = 1'b0;
    exec("not", 16'h0200, 16'h0200, 5'b10001, ZLOW, 16'h0020, 1'b0);

    // illegal opcode 11111, then halt while run stays high
    fetch("ill", 32'hF8918000);
    tick(); chk_st("ill T3", 16'h0, 16'h0, 16'h0); chk("ill pulse", illegal, 1'b1);
    tick(); chk("ill END pulse", illegal, 1'b0); chk("ill END in_sel", reg_in_sel, 16'h0);
    ir = 32'hD8000000;
    tick(); chk("next fetch T0", strb(), T0S);
    tick(); chk("halt T1", strb(), T1S);
    tick(); chk("halt T2", strb(), T2S);
    tick(); chk("halt T3 strb", strb(), 16'h0); chk("halt T3 halted", halted, 1'b0);
    tick(); chk("halted", halted, 1'b1); chk("halted busy", busy, 1'b0);
    repeat (3) tick();
    chk("halt sticky", halted, 1'b1); chk("halt strb", strb(), 16'h0);
    run = 1'b0; clr = 1'b0;
    tick(); chk("halt cleared", halted, 1'b0);
    clr = 1'b1;

    // read timeout: mem_ready low for 20 cycles in T1
    ir = 32'h18918000; run = 1'b1; mem_ready = 1'b0;
    tick(); chk("to T0", strb(), T0S);
    tick(); chk("to T1", strb(), T1S);
    repeat (14) tick();
    chk("timeout 14", read_timeout, 1'b0);
    tick(); chk("timeout 15", read_timeout, 1'b1);
    repeat (5) tick();
    chk("to T1 held", strb(), T1S);
    mem_ready = 1'b1;
    tick(); chk("to T2", strb(), T2S);
    run = 1'b0;
    wait_idle("to idle");
    chk("timeout sticky", read_timeout, 1'b1);

    // reset mid-T4
    fetch("rst", 32'h18918000); run = 1'b0;
    tick(); tick();
    chk("rst T4 alu_op", alu_op, 5'b00011);
    clr = 1'b0; #1;
    chk_st("rst async", 16'h0, 16'h0, 16'h0);
    chk("rst alu_op", alu_op, 5'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst timeout", read_timeout, 1'b0);
    tick(); clr = 1'b1;
    tick(); chk("rst idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
